// File: rtl/mem_pkg.sv
// Shared memory-side types: line/beat words, per-beat view of a line, and the adapter FSM states.
package mem_pkg;
   localparam int LINE_OFFSET_BITS = 5;
   localparam int BEAT_OFFSET_BITS = 3;
   localparam int LINE_BITS        = 256;
   localparam int BEAT_BITS        = 64;
   localparam int NUM_BEATS        = LINE_BITS / BEAT_BITS;

   typedef logic [LINE_BITS-1:0] line_t;
   typedef logic [BEAT_BITS-1:0] beat_t;
   typedef logic [NUM_BEATS-1:0][BEAT_BITS-1:0] beat_vec_t;

   typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} lba_state_e;
endpackage

// File: rtl/line_burst_adapter_if.sv
// Line-side request/response and burst-side beat signals of the line/burst adapter.
interface line_burst_adapter_if;
   logic [31:0]     line_addr;
   mem_pkg::line_t  line_wdata;
   mem_pkg::line_t  line_rdata;
   logic            line_read;
   logic            line_write;
   logic            line_resp;
   logic [31:0]     burst_addr;
   mem_pkg::beat_t  burst_wdata;
   mem_pkg::beat_t  burst_rdata;
   logic            burst_read;
   logic            burst_write;
   logic            burst_resp;
   logic            timeout_err;

   modport slave (
      input  line_addr, line_wdata, line_read, line_write, burst_rdata, burst_resp,
      output line_rdata, line_resp, burst_addr, burst_wdata, burst_read, burst_write, timeout_err
   );

   modport master (
      output line_addr, line_wdata, line_read, line_write, burst_rdata, burst_resp,
      input  line_rdata, line_resp, burst_addr, burst_wdata, burst_read, burst_write, timeout_err
   );
endinterface

// File: rtl/lba_beat_counter.sv
// Beat index within a line burst: advances on inc, returns to 0 on clr; last flags the final beat.
module lba_beat_counter #(
   parameter  int BEATS = 4,
   localparam int IDX_W = $clog2(BEATS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [IDX_W-1:0] idx,
   output logic             last
);
   logic [IDX_W-1:0] idx_q, idx_d;

   always_comb begin
      idx_d = idx_q;
      if (clr) begin
         idx_d = '0;
      end else if (inc) begin
         idx_d = idx_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q <= '0;
      end else begin
         idx_q <= idx_d;
      end
   end

   assign idx  = idx_q;
   assign last = (idx_q == IDX_W'(BEATS - 1));
endmodule

// File: rtl/line_burst_adapter.sv
// Line <-> 4-beat burst adapter, one transaction in flight, >= 6 cycles per line; beats stall on burst_resp.
// Requester holds line_read/line_write until line_resp. LBA_TIMEOUT_EN adds a stall watchdog (timeout_err).
module line_burst_adapter
   import mem_pkg::*;
#(
   parameter int LINE_WIDTH     = 256,
   parameter int BEAT_WIDTH     = 64,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input logic                 clk,
   input logic                 rst_n,
   line_burst_adapter_if.slave bus
);
   localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
   localparam int IDX_W = $clog2(BEATS);

   lba_state_e                  state_q, state_d;
   logic [31:LINE_OFFSET_BITS]  base_q, base_d;
   beat_vec_t                   wdata_q, wdata_d;
   beat_vec_t                   rdata_q, rdata_d;
   logic [IDX_W-1:0]            beat_idx;
   logic                        beat_last;
   logic                        beat_inc;
   logic                        beat_clr;
   logic                        bursting;
   logic                        addr_unused;

`ifdef LBA_TIMEOUT_EN
   logic [31:0] wdog_q, wdog_d;
   logic        terr_q, terr_d;
`endif

   assign addr_unused = ^bus.line_addr[LINE_OFFSET_BITS-1:0];

   lba_beat_counter #(.BEATS(BEATS)) u_beat_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .inc  (beat_inc),
      .clr  (beat_clr),
      .idx  (beat_idx),
      .last (beat_last)
   );

   always_comb begin
      state_d         = state_q;
      base_d          = base_q;
      wdata_d         = wdata_q;
      rdata_d         = rdata_q;
      beat_inc        = 1'b0;
      beat_clr        = 1'b0;
      bursting        = (state_q == RD_BURST) || (state_q == WR_BURST);
      bus.line_resp   = 1'b0;
      bus.burst_read  = 1'b0;
      bus.burst_write = 1'b0;
      bus.burst_wdata = '0;
      bus.burst_addr  = '0;
`ifdef LBA_TIMEOUT_EN
      wdog_d          = '0;
      terr_d          = terr_q;
`endif
      case (state_q)
         IDLE: begin
            // Write has priority; a concurrent read stays pending at the requester.
            if (bus.line_write) begin
               base_d  = bus.line_addr[31:LINE_OFFSET_BITS];
               wdata_d = bus.line_wdata;
               state_d = WR_BURST;
            end else if (bus.line_read) begin
               base_d  = bus.line_addr[31:LINE_OFFSET_BITS];
               state_d = RD_BURST;
            end
         end
         RD_BURST: begin
            bus.burst_read = 1'b1;
            if (bus.burst_resp) begin
               rdata_d[beat_idx] = bus.burst_rdata;
               beat_inc          = 1'b1;
               if (beat_last) state_d = DONE;
            end
         end
         WR_BURST: begin
            bus.burst_write = 1'b1;
            bus.burst_wdata = wdata_q[beat_idx];
            if (bus.burst_resp) begin
               beat_inc = 1'b1;
               if (beat_last) state_d = DONE;
            end
         end
         DONE: begin
            bus.line_resp = 1'b1;
            beat_clr      = 1'b1;
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (bursting) begin
         bus.burst_addr = {base_q, beat_idx, {BEAT_OFFSET_BITS{1'b0}}};
      end

`ifdef LBA_TIMEOUT_EN
      // Any accepted beat restarts the stall window; expiry abandons the remaining beats.
      if (bursting && !bus.burst_resp) begin
         wdog_d = wdog_q + 32'd1;
         if (wdog_d == 32'(TIMEOUT_CYCLES)) begin
            wdog_d  = '0;
            terr_d  = 1'b1;
            state_d = DONE;
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         base_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

`ifdef LBA_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdog_q <= '0;
         terr_q <= 1'b0;
      end else begin
         wdog_q <= wdog_d;
         terr_q <= terr_d;
      end
   end

   assign bus.timeout_err = terr_q;
`else
   logic [31:0] tmo_unused;
   assign tmo_unused      = 32'(TIMEOUT_CYCLES);
   assign bus.timeout_err = 1'b0;
`endif

   assign bus.line_rdata = rdata_q;
endmodule
